// File: rtl/nds_pkg.sv
// Shared constants, pixel payload type and FSM states for the NDS top-LCD capture path.
// NDS_DOUBLE_BUFFER_EN adds a bank bit above the 16-bit frame address.
package nds_pkg;

   localparam int unsigned NDS_W      = 256;
   localparam int unsigned NDS_H      = 192;
   localparam int unsigned NDS_ADDR_W = 16;
   localparam int unsigned NDS_PIX_W  = 18;

`ifdef NDS_DOUBLE_BUFFER_EN
   localparam int unsigned NDS_BRAM_AW = NDS_ADDR_W + 1;
`else
   localparam int unsigned NDS_BRAM_AW = NDS_ADDR_W;
`endif

   typedef struct packed {
      logic [5:0] r;
      logic [5:0] g;
      logic [5:0] b;
   } rgb666_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_VS,
      ST_V_SKIPPING,
      ST_WAIT_HS,
      ST_H_SKIPPING,
      ST_ACTIVE,
      ST_FRAME_END
   } cap_state_e;

endpackage

// File: rtl/nds_input_sync.sv
// Synchronizes the asynchronous NDS LCD bus into pixel_clk and produces registered
// dclk_rise / hs_rel / vs_rel pulses with pixel data aligned to dclk_rise.
module nds_input_sync
   import nds_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic    pixel_clk,
   input  logic    reset,
   input  logic    nds_dclk,
   input  logic    nds_hs_n,
   input  logic    nds_vs_n,
   input  rgb666_t nds_pix,
   output rgb666_t pix,
   output logic    dclk_rise,
   output logic    hs_rel,
   output logic    vs_rel
);

   localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int unsigned PIX_W  = $bits(rgb666_t);
   localparam int unsigned IN_W   = 3 + PIX_W;

   logic [IN_W-1:0] sync_q [STAGES];
   logic [IN_W-1:0] sync_d [STAGES];
   logic [2:0]      ctrl_prev_q, ctrl_prev_d;
   logic [STAGES:0] fill_q, fill_d;
   logic [2:0]      ctrl_c;
   rgb666_t         pix_q, pix_d;
   logic            dclk_rise_q, dclk_rise_d;
   logic            hs_rel_q, hs_rel_d;
   logic            vs_rel_q, vs_rel_d;

   // Edges are masked until the chain holds real pin samples, so the cleared
   // flops rising to idle-high levels after reset never look like a sync release.
   always_comb begin
      sync_d[0] = {nds_dclk, nds_hs_n, nds_vs_n, nds_pix};
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      ctrl_c      = sync_q[STAGES-1][IN_W-1 -: 3];
      ctrl_prev_d = ctrl_c;
      fill_d      = {fill_q[STAGES-1:0], 1'b1};
      dclk_rise_d = fill_q[STAGES] & ctrl_c[2] & ~ctrl_prev_q[2];
      hs_rel_d    = fill_q[STAGES] & ctrl_c[1] & ~ctrl_prev_q[1];
      vs_rel_d    = fill_q[STAGES] & ctrl_c[0] & ~ctrl_prev_q[0];
      pix_d       = rgb666_t'(sync_q[STAGES-1][PIX_W-1:0]);
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
         ctrl_prev_q <= '0;
         fill_q      <= '0;
         pix_q       <= '0;
         dclk_rise_q <= 1'b0;
         hs_rel_q    <= 1'b0;
         vs_rel_q    <= 1'b0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         ctrl_prev_q <= ctrl_prev_d;
         fill_q      <= fill_d;
         pix_q       <= pix_d;
         dclk_rise_q <= dclk_rise_d;
         hs_rel_q    <= hs_rel_d;
         vs_rel_q    <= vs_rel_d;
      end
   end

   assign pix       = pix_q;
   assign dclk_rise = dclk_rise_q;
   assign hs_rel    = hs_rel_q;
   assign vs_rel    = vs_rel_q;

endmodule

// File: rtl/nds_capture_writer.sv
// Captures NDS top-LCD RGB666 frames into BRAM at address y*256+x, one pixel per word.
// Define NDS_DOUBLE_BUFFER_EN for a two-bank buffer with a disp_bank output.
module nds_capture_writer
   import nds_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = NDS_W,
   parameter int unsigned V_ACTIVE    = NDS_H,
   parameter int unsigned H_SKIP      = 0,
   parameter int unsigned V_SKIP      = 0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   pixel_clk,
   input  logic                   reset,
   input  logic                   nds_dclk,
   input  logic                   nds_hs_n,
   input  logic                   nds_vs_n,
   input  logic [5:0]             nds_r,
   input  logic [5:0]             nds_g,
   input  logic [5:0]             nds_b,
   input  logic                   capture_en,
   output logic                   bram_en,
   output logic                   bram_we,
   output logic [NDS_BRAM_AW-1:0] bram_addr,
   output logic [NDS_PIX_W-1:0]   bram_din,
   output logic                   frame_done,
   output logic [7:0]             frame_count,
   output logic                   err_sticky
`ifdef NDS_DOUBLE_BUFFER_EN
   ,
   output logic                   disp_bank
`endif
);

   localparam int unsigned X_W    = 9;
   localparam int unsigned Y_W    = 8;
   localparam int unsigned SKIP_W = 10;

   localparam cap_state_e H_ENTRY = (H_SKIP == 0) ? ST_ACTIVE  : ST_H_SKIPPING;
   localparam cap_state_e V_ENTRY = (V_SKIP == 0) ? ST_WAIT_HS : ST_V_SKIPPING;

   rgb666_t nds_pix_c;
   rgb666_t pix;
   logic    dclk_rise, hs_rel, vs_rel;

   assign nds_pix_c = '{r: nds_r, g: nds_g, b: nds_b};

   nds_input_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .nds_dclk  (nds_dclk),
      .nds_hs_n  (nds_hs_n),
      .nds_vs_n  (nds_vs_n),
      .nds_pix   (nds_pix_c),
      .pix       (pix),
      .dclk_rise (dclk_rise),
      .hs_rel    (hs_rel),
      .vs_rel    (vs_rel)
   );

   cap_state_e             state_q, state_d;
   logic [X_W-1:0]         x_q, x_d;
   logic [Y_W-1:0]         y_q, y_d;
   logic [SKIP_W-1:0]      skip_q, skip_d;
   logic                   err_q, err_d;
   logic [7:0]             fc_q, fc_d;
   logic                   fd_q, fd_d;
   logic                   we_q, we_d;
   logic [NDS_BRAM_AW-1:0] addr_q, addr_d;
   logic [NDS_PIX_W-1:0]   din_q, din_d;
   logic                   x_last_c, y_last_c;
`ifdef NDS_DOUBLE_BUFFER_EN
   logic                   wr_bank_q, wr_bank_d;
   logic                   disp_bank_q, disp_bank_d;
`endif

   assign x_last_c = (x_q == X_W'(H_ACTIVE - 1));
   assign y_last_c = (y_q == Y_W'(V_ACTIVE - 1));

   // Next-state, counters and the registered write strobe.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      skip_d  = skip_q;
      err_d   = err_q;
      fc_d    = fc_q;
      fd_d    = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      din_d   = '0;
`ifdef NDS_DOUBLE_BUFFER_EN
      wr_bank_d   = wr_bank_q;
      disp_bank_d = disp_bank_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (capture_en) state_d = ST_WAIT_VS;
         end
         ST_WAIT_VS: begin
            if (!capture_en) begin
               state_d = ST_IDLE;
            end else if (vs_rel) begin
               x_d     = '0;
               y_d     = '0;
               skip_d  = '0;
               state_d = V_ENTRY;
            end
         end
         ST_V_SKIPPING: begin
            if (hs_rel) begin
               if (skip_q == SKIP_W'(V_SKIP - 1)) begin
                  skip_d  = '0;
                  state_d = ST_WAIT_HS;
               end else begin
                  skip_d = skip_q + SKIP_W'(1);
               end
            end
         end
         ST_WAIT_HS: begin
            if (hs_rel) begin
               x_d     = '0;
               skip_d  = '0;
               state_d = H_ENTRY;
            end
         end
         ST_H_SKIPPING, ST_ACTIVE: begin
            // A line ending early still advances y; it wins over a same-cycle dclk.
            if (hs_rel) begin
               err_d  = 1'b1;
               x_d    = '0;
               skip_d = '0;
               if (y_last_c) begin
                  state_d = ST_FRAME_END;
               end else begin
                  y_d     = y_q + Y_W'(1);
                  state_d = H_ENTRY;
               end
            end else if (dclk_rise) begin
               if (state_q == ST_H_SKIPPING) begin
                  if (skip_q == SKIP_W'(H_SKIP - 1)) begin
                     skip_d  = '0;
                     state_d = ST_ACTIVE;
                  end else begin
                     skip_d = skip_q + SKIP_W'(1);
                  end
               end else begin
                  we_d  = 1'b1;
                  din_d = pix;
`ifdef NDS_DOUBLE_BUFFER_EN
                  addr_d = {wr_bank_q, y_q, x_q[7:0]};
`else
                  addr_d = {y_q, x_q[7:0]};
`endif
                  if (x_last_c) begin
                     x_d = '0;
                     if (y_last_c) begin
                        state_d = ST_FRAME_END;
                     end else begin
                        y_d     = y_q + Y_W'(1);
                        state_d = ST_WAIT_HS;
                     end
                  end else begin
                     x_d = x_q + X_W'(1);
                  end
               end
            end
         end
         ST_FRAME_END: begin
            fd_d = 1'b1;
            fc_d = fc_q + 8'd1;
            x_d  = '0;
            y_d  = '0;
`ifdef NDS_DOUBLE_BUFFER_EN
            disp_bank_d = wr_bank_q;
            wr_bank_d   = ~wr_bank_q;
`endif
            // A VSYNC landing on this cycle already starts the next frame.
            if (!capture_en) begin
               state_d = ST_IDLE;
            end else if (vs_rel) begin
               skip_d  = '0;
               state_d = V_ENTRY;
            end else begin
               state_d = ST_WAIT_VS;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Premature VSYNC abandons the partial frame without a frame_done.
      if (vs_rel && (state_q inside {ST_V_SKIPPING, ST_WAIT_HS, ST_H_SKIPPING, ST_ACTIVE})) begin
         err_d   = 1'b1;
         x_d     = '0;
         y_d     = '0;
         skip_d  = '0;
         we_d    = 1'b0;
         addr_d  = '0;
         din_d   = '0;
         state_d = V_ENTRY;
      end
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         skip_q  <= '0;
         err_q   <= 1'b0;
         fc_q    <= '0;
         fd_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
`ifdef NDS_DOUBLE_BUFFER_EN
         wr_bank_q   <= 1'b0;
         disp_bank_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         skip_q  <= skip_d;
         err_q   <= err_d;
         fc_q    <= fc_d;
         fd_q    <= fd_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
`ifdef NDS_DOUBLE_BUFFER_EN
         wr_bank_q   <= wr_bank_d;
         disp_bank_q <= disp_bank_d;
`endif
      end
   end

   assign bram_en     = we_q;
   assign bram_we     = we_q;
   assign bram_addr   = addr_q;
   assign bram_din    = din_q;
   assign frame_done  = fd_q;
   assign frame_count = fc_q;
   assign err_sticky  = err_q;
`ifdef NDS_DOUBLE_BUFFER_EN
   assign disp_bank   = disp_bank_q;
`endif

endmodule

// File: tb/tb_nds_capture_writer.sv
// Scoreboard bench for nds_capture_writer on a reduced 16x8 frame with H_SKIP=3, V_SKIP=2;
// addresses keep the y*256+x layout. Handles NDS_DOUBLE_BUFFER_EN when defined.
module tb_nds_capture_writer;
   import nds_pkg::*;

   localparam int unsigned HA = 16;
   localparam int unsigned VA = 8;
   localparam int unsigned HS = 3;
   localparam int unsigned VS = 2;
   localparam int unsigned SS = 2;
   localparam int unsigned AW = NDS_BRAM_AW;
   localparam int CLK_HALF = 20;
   localparam int DHALF    = 88;
   localparam logic [17:0] MARKER = 18'h2AAAA;

   logic          pixel_clk;
   logic          reset;
   logic          nds_dclk, nds_hs_n, nds_vs_n;
   logic [5:0]    nds_r, nds_g, nds_b;
   logic          capture_en;
   logic          bram_en, bram_we;
   logic [AW-1:0] bram_addr;
   logic [17:0]   bram_din;
   logic          frame_done;
   logic [7:0]    frame_count;
   logic          err_sticky;
`ifdef NDS_DOUBLE_BUFFER_EN
   logic          disp_bank;
`endif

   nds_capture_writer #(
      .H_ACTIVE    (HA),
      .V_ACTIVE    (VA),
      .H_SKIP      (HS),
      .V_SKIP      (VS),
      .SYNC_STAGES (SS)
   ) dut (
      .pixel_clk   (pixel_clk),
      .reset       (reset),
      .nds_dclk    (nds_dclk),
      .nds_hs_n    (nds_hs_n),
      .nds_vs_n    (nds_vs_n),
      .nds_r       (nds_r),
      .nds_g       (nds_g),
      .nds_b       (nds_b),
      .capture_en  (capture_en),
      .bram_en     (bram_en),
      .bram_we     (bram_we),
      .bram_addr   (bram_addr),
      .bram_din    (bram_din),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .err_sticky  (err_sticky)
`ifdef NDS_DOUBLE_BUFFER_EN
      ,
      .disp_bank   (disp_bank)
`endif
   );

   initial begin
      pixel_clk = 1'b0;
      forever #CLK_HALF pixel_clk = ~pixel_clk;
   end

   int              n_cmp = 0;
   int              n_bad = 0;
   logic [AW+17:0]  exp_q [$];
   int              fd_seen = 0;
   int              marker_seen = 0;
   int              exp_fd = 0;
   int              exp_fc = 0;
   bit              exp_bank = 1'b0;
   bit              lat_armed = 1'b0;
   int              lat_edges = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic [17:0] pix_val(input int y, input int x);
      return 18'(y * 256 + x);
   endfunction

   function automatic logic [AW-1:0] pix_addr(input int y, input int x);
      logic [15:0] a;
      a = 16'(y * 256 + x);
`ifdef NDS_DOUBLE_BUFFER_EN
      return {exp_bank, a};
`else
      return a;
`endif
   endfunction

   // Data changes with dclk low; the rising edge lands DHALF later.
   task automatic nds_pixel(input logic [17:0] v, input bit push, input bit arm, input logic [AW-1:0] a);
      {nds_r, nds_g, nds_b} = v;
      nds_dclk = 1'b0;
      if (push) exp_q.push_back({a, v});
      #DHALF;
      nds_dclk = 1'b1;
      if (arm) begin
         lat_edges = 0;
         lat_armed = 1'b1;
      end
      #DHALF;
   endtask

   task automatic hsync_pulse();
      nds_hs_n = 1'b0;
      #(2 * DHALF);
      nds_hs_n = 1'b1;
      #(2 * DHALF);
   endtask

   task automatic vsync_pulse();
      nds_vs_n = 1'b0;
      #(4 * DHALF);
      nds_vs_n = 1'b1;
      #(2 * DHALF);
   endtask

   task automatic drive_line(input int y, input int npix, input bit wr, input bit trailing, input bit arm);
      hsync_pulse();
      repeat (HS) nds_pixel(MARKER, 1'b0, 1'b0, '0);
      for (int x = 0; x < npix; x++)
         nds_pixel(pix_val(y, x), wr, arm && (x == 0), pix_addr(y, x));
      if (trailing) repeat (2) nds_pixel(MARKER, 1'b0, 1'b0, '0);
   endtask

   task automatic drive_frame(input int short_line, input int abort_line, input int en_off_line,
                              input bit wr, input bit arm);
      vsync_pulse();
      repeat (VS) begin
         hsync_pulse();
         repeat (4) nds_pixel(MARKER, 1'b0, 1'b0, '0);
      end
      for (int y = 0; y < int'(VA); y++) begin
         if (y == en_off_line) capture_en = 1'b0;
         if (y == abort_line) begin
            drive_line(y, 5, wr, 1'b0, 1'b0);
            return;
         end
         if (y == short_line) drive_line(y, 10, wr, 1'b0, 1'b0);
         else                 drive_line(y, int'(HA), wr, 1'b1, arm && (y == 0));
      end
      if (wr) begin
         exp_fd++;
         exp_fc++;
         exp_bank = ~exp_bank;
      end
   endtask

   task automatic settle_and_check(input string tag, input bit exp_err);
      repeat (30) @(negedge pixel_clk);
      check({tag, "_frame_done_pulses"}, 64'(fd_seen), 64'(exp_fd));
      check({tag, "_frame_count"}, 64'(frame_count), 64'(exp_fc));
      check({tag, "_err_sticky"}, 64'(err_sticky), 64'(exp_err));
`ifdef NDS_DOUBLE_BUFFER_EN
      check({tag, "_disp_bank"}, 64'(disp_bank), 64'(~exp_bank));
`endif
      #3;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_bram_we"}, 64'(bram_we), 64'd0);
      check({tag, "_bram_en"}, 64'(bram_en), 64'd0);
      check({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
      check({tag, "_bram_din"}, 64'(bram_din), 64'd0);
      check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
      check({tag, "_frame_count"}, 64'(frame_count), 64'd0);
      check({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
`ifdef NDS_DOUBLE_BUFFER_EN
      check({tag, "_disp_bank"}, 64'(disp_bank), 64'd1);
`endif
   endtask

   initial begin
      bit found;
      reset      = 1'b1;
      capture_en = 1'b0;
      nds_dclk   = 1'b1;
      nds_hs_n   = 1'b1;
      nds_vs_n   = 1'b1;
      {nds_r, nds_g, nds_b} = '0;

      fork
         begin : monitor
            logic [AW+17:0] got, e;
            forever begin
               @(posedge pixel_clk);
               if (lat_armed) lat_edges++;
               @(negedge pixel_clk);
               if (frame_done) fd_seen++;
               if (bram_en !== bram_we) check("bram_en_eq_we", 64'(bram_en), 64'(bram_we));
               if (bram_we) begin
                  got = {bram_addr, bram_din};
                  if (bram_din == MARKER) marker_seen++;
                  if (lat_armed) begin
                     check("pin_to_write_cycles", 64'(lat_edges), 64'(SS + 2));
                     lat_armed = 1'b0;
                  end
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL unexpected_write: got addr %0h din %0h, required no write",
                              bram_addr, bram_din);
                  end else begin
                     e = exp_q.pop_front();
                     check("write_addr_din", 64'(got), 64'(e));
                  end
               end
            end
         end
      join_none

      repeat (4) @(negedge pixel_clk);
      check_outputs_zero("por");
      #3;
      reset = 1'b0;
      repeat (4) @(negedge pixel_clk);
      #3;

      // Frame A: nominal, with skip markers and post-line dclks.
      capture_en = 1'b1;
      drive_frame(-1, -1, -1, 1'b1, 1'b1);
      settle_and_check("nominal", 1'b0);

      // Frame B abandoned at line 3; frame C's VSYNC is premature for B.
      drive_frame(-1, 3, -1, 1'b1, 1'b0);
      repeat (10) @(negedge pixel_clk);
      check("before_premature_err", 64'(err_sticky), 64'd0);
      #3;
      drive_frame(-1, -1, -1, 1'b1, 1'b0);
      settle_and_check("premature_vs", 1'b1);

      // Reset while line 0 is being written, right after pixel x=7 lands.
      vsync_pulse();
      repeat (VS) begin
         hsync_pulse();
         repeat (4) nds_pixel(MARKER, 1'b0, 1'b0, '0);
      end
      hsync_pulse();
      repeat (HS) nds_pixel(MARKER, 1'b0, 1'b0, '0);
      for (int x = 0; x < 8; x++) nds_pixel(pix_val(0, x), 1'b1, 1'b0, pix_addr(0, x));
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge pixel_clk);
         if (bram_we && bram_addr[7:0] == 8'd7) begin
            found = 1'b1;
            break;
         end
      end
      check("reset_test_write_seen", 64'(found), 64'd1);
      #5;
      check("queue_before_reset", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      reset = 1'b1;
      #1;
      check_outputs_zero("midline_reset");
      repeat (3) @(negedge pixel_clk);
      #3;
      reset = 1'b0;
      exp_bank = 1'b0;
      exp_fc = 0;
      for (int x = 8; x < int'(HA); x++) nds_pixel(pix_val(0, x), 1'b0, 1'b0, '0);
      drive_line(1, int'(HA), 1'b0, 1'b1, 1'b0);
      repeat (10) @(negedge pixel_clk);
      check("after_reset_no_capture_count", 64'(frame_count), 64'd0);
      #3;

      // Frame D restarts at the next VSYNC, frame E has a short line 5.
      drive_frame(-1, -1, -1, 1'b1, 1'b0);
      settle_and_check("after_reset", 1'b0);
      drive_frame(5, -1, -1, 1'b1, 1'b0);
      settle_and_check("short_line", 1'b1);

      // Frame F drops capture_en mid-frame; frame G must not be captured.
      drive_frame(-1, -1, 2, 1'b1, 1'b0);
      settle_and_check("en_off", 1'b1);
      drive_frame(-1, -1, -1, 1'b0, 1'b0);
      settle_and_check("idle_frame", 1'b1);

      check("pending_writes", 64'(exp_q.size()), 64'd0);
      check("marker_writes", 64'(marker_seen), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
